mux4a1_rr_sched: RTL

MUX4A1_RR_SCHED -- requirements
Module: mux4a1_rr_sched

---
 rtl/mux4a1_rr_sched_pkg.sv | 30 +++
 rtl/mux4a1_rr_sched_fifo.sv | 72 +++++++
 rtl/mux4a1_rr_sched.sv | 90 +++++++++
 3 files changed

// File: rtl/mux4a1_rr_sched_pkg.sv
// rtl/mux4a1_rr_sched_pkg.sv - shared constants, grant type and round-robin pick helper
package mux4a1_rr_sched_pkg;

  localparam int LANES      = 4;
  localparam int SEL_W      = 2;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  typedef struct packed {
    logic             valid;
    logic [SEL_W-1:0] idx;
  } grant_t;

  // First eligible lane at or after ptr, wrapping modulo LANES.
  function automatic grant_t rr_pick(input logic [LANES-1:0] elig,
                                     input logic [SEL_W-1:0] ptr);
    grant_t           g;
    logic [SEL_W-1:0] k;
    g = '0;
    for (int i = 0; i < LANES; i++) begin
      k = ptr + SEL_W'(i);
      if (!g.valid && elig[k]) begin
        g.valid = 1'b1;
        g.idx   = k;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/mux4a1_rr_sched_fifo.sv
// rtl/mux4a1_rr_sched_fifo.sv - per-lane first-word-fall-through FIFO with registered flags
module sync_fifo_lane #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;

  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count_nxt;

  // A push against a full lane is dropped even if the lane pops this cycle.
  assign w_push      = i_push && !r_full;
  assign w_pop       = i_pop && !r_empty;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      if (i_push && r_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_data     = r_mem[r_rd_ptr];
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/mux4a1_rr_sched.sv
// rtl/mux4a1_rr_sched.sv - four lane FIFOs feeding a round-robin arbiter and one-word output stage
module mux4a1_rr_sched
  import mux4a1_rr_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [LANES-1:0]  valid_in,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [LANES-1:0]  lane_en,
  input  logic              ready_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [SEL_W-1:0]  sel_out,
  output logic [LANES-1:0]  full,
  output logic [LANES-1:0]  empty,
  output logic [LANES-1:0]  overflow_err
);

  logic [DATA_W-1:0] w_din  [LANES];
  logic [DATA_W-1:0] w_head [LANES];
  logic [LANES-1:0]  w_pop;
  logic              w_load;
  grant_t            w_grant;

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  r_rr_ptr;

  assign w_din[0] = data_in0;
  assign w_din[1] = data_in1;
  assign w_din[2] = data_in2;
  assign w_din[3] = data_in3;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    sync_fifo_lane #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .i_clk      (clk_4f),
      .i_reset    (reset),
      .i_push     (valid_in[gi]),
      .i_data     (w_din[gi]),
      .i_pop      (w_pop[gi]),
      .o_data     (w_head[gi]),
      .o_full     (full[gi]),
      .o_empty    (empty[gi]),
      .o_overflow (overflow_err[gi])
    );
  end

  // A stalled output word blocks arbitration, so no lane pops while it waits.
  always_comb begin
    w_load  = !r_valid || ready_out;
    w_grant = rr_pick(~empty & lane_en, r_rr_ptr);
    w_pop   = '0;
    if (w_load && w_grant.valid) begin
      w_pop[w_grant.idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_sel    <= '0;
      r_rr_ptr <= '0;
    end else if (w_load) begin
      if (w_grant.valid) begin
        r_valid  <= 1'b1;
        r_data   <= w_head[w_grant.idx];
        r_sel    <= w_grant.idx;
        r_rr_ptr <= w_grant.idx + SEL_W'(1);
      end else begin
        r_valid  <= 1'b0;
      end
    end
  end

  assign valid_out = r_valid;
  assign data_out  = r_data;
  assign sel_out   = r_sel;

endmodule
